ctrl_cas_sched: RTL

Parametrised, queued successor to the single-request CAS timing controller. Accepts ACT or no-ACT column requests from the burst/ACT stage into a DEPTH-entry in-order queue. Tracks per-entry tRCD readiness and enforces tCCD, write-to-read and read-to-write turnaround. Issues one CAS per command slot to the command encoder; carries the bank address alongside each request.

---
 rtl/ddr_pkg.sv | 30 +++
 rtl/cas_gap_calc.sv | 35 +++
 rtl/ctrl_cas_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// Shared DDR controller types: request codes, CAS scheduler FSM/class enums, queue entry.
package ddr_pkg;

  localparam logic [2:0] RD_R  = 3'd1;
  localparam logic [2:0] RDA_R = 3'd2;
  localparam logic [2:0] WR_R  = 3'd3;
  localparam logic [2:0] WRA_R = 3'd4;

  // Entry fields are sized for the widest configuration; users slice down.
  localparam int BANK_W_MAX = 16;
  localparam int RCD_W      = 16;

  typedef enum logic [1:0] {CAS_IDLE, CAS_WAIT, CAS_CMD} cas_sched_fsm_type;
  typedef enum logic [1:0] {CLS_NONE, CLS_READ, CLS_WRITE} rw_class_type;

  typedef struct packed {
    logic [2:0]            req;
    logic [BANK_W_MAX-1:0] bank;
    logic [RCD_W-1:0]      rcd;
  } cas_entry_t;

  function automatic rw_class_type rw_class(input logic [2:0] req);
    case (req)
      RD_R, RDA_R: rw_class = CLS_READ;
      WR_R, WRA_R: rw_class = CLS_WRITE;
      default:     rw_class = CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cas_gap_calc.sv
// Required CK gap between the previous CAS and the head CAS, from the bus-direction change.
module cas_gap_calc import ddr_pkg::*; #(
  parameter int CNT_W = 8,
  parameter int TWTR  = 8
) (
  input  rw_class_type       last_cls,
  input  rw_class_type       head_cls,
  input  logic [CNT_W-1:0]   tccd,
  input  logic [CNT_W-1:0]   cl,
  input  logic [CNT_W-1:0]   al,
  input  logic [CNT_W-1:0]   cwl,
  input  logic [CNT_W-1:0]   bl,
  output logic [CNT_W+1:0]   gap
);
  localparam int GW = CNT_W + 2;

  logic [GW-1:0] half_bl, w2r, rd_lat, wr_lat, r2w_turn, r2w;

  always_comb begin
    half_bl  = GW'(bl) >> 1;
    w2r      = GW'(cwl) + half_bl + GW'(TWTR);
    rd_lat   = GW'(cl) + GW'(al) + half_bl + GW'(2);
    wr_lat   = GW'(cwl) + GW'(al);
    // Large CWL can make the raw read-to-write turnaround negative; clamp it.
    r2w_turn = (rd_lat > wr_lat) ? rd_lat - wr_lat : '0;
    r2w      = (r2w_turn > GW'(tccd)) ? r2w_turn : GW'(tccd);
    gap      = '0;
    if (last_cls != CLS_NONE) begin
      if (last_cls == head_cls)                              gap = GW'(tccd);
      else if (last_cls == CLS_WRITE && head_cls == CLS_READ) gap = w2r;
      else if (last_cls == CLS_READ && head_cls == CLS_WRITE) gap = r2w;
    end
  end

endmodule

// File: rtl/ctrl_cas_sched.sv
// Queued in-order CAS scheduler: tRCD per entry, tCCD and WR/RD turnaround between issues.
// Optional statistics counters enabled by defining CAS_SCHED_STATS_EN.
module ctrl_cas_sched import ddr_pkg::*; #(
  parameter int DEPTH  = 8,
  parameter int BANK_W = 4,
  parameter int TRCD   = 16,
  parameter int TWTR   = 8,
  parameter int CNT_W  = 8
) (
  input  logic                   CK_t,
  input  logic                   reset,
  input  logic                   act_rdy,
  input  logic                   no_act_rdy,
  input  logic [2:0]             act_rw,
  input  logic [BANK_W-1:0]      act_bank,
  input  logic [CNT_W-1:0]       tCCD,
  input  logic [CNT_W-1:0]       CL,
  input  logic [CNT_W-1:0]       AL,
  input  logic [CNT_W-1:0]       CWL,
  input  logic [CNT_W-1:0]       BL,
  output logic                   cas_rdy,
  output logic [2:0]             cas_req,
  output logic [BANK_W-1:0]      cas_bank,
  output logic                   cas_idle,
  output logic                   q_full,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   overflow,
  output logic [31:0]            rd_cnt,
  output logic [31:0]            wr_cnt,
  output logic [31:0]            stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = CNT_W + 2;
  localparam logic [AW:0]      FULL   = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] SL_MAX = '1;

  cas_entry_t        q_mem [DEPTH];
  cas_entry_t        head;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_nxt;
  cas_sched_fsm_type state;
  rw_class_type      last_cls, head_cls;
  logic [CNT_W-1:0]  since_last;
  logic [GW-1:0]     gap;
  logic              empty, push, push_ok, issue, unused_bank;

  assign head        = q_mem[rd_ptr];
  assign head_cls    = rw_class(head.req);
  assign empty       = (count == '0);
  assign push        = act_rdy | no_act_rdy;
  assign unused_bank = ^head.bank;

  cas_gap_calc #(.CNT_W(CNT_W), .TWTR(TWTR)) u_gap (
    .last_cls (last_cls),
    .head_cls (head_cls),
    .tccd     (tCCD),
    .cl       (CL),
    .al       (AL),
    .cwl      (CWL),
    .bl       (BL),
    .gap      (gap)
  );

  // rcd reaches 0 on the same edge that would issue, so rcd==1 already clears tRCD.
  assign issue     = (state != CAS_IDLE) && !empty && (head.rcd <= RCD_W'(1)) &&
                     (({2'b00, since_last} + GW'(1)) >= gap);
  assign push_ok   = push && (!q_full || issue);
  assign count_nxt = count + (AW+1)'(push_ok) - (AW+1)'(issue);

  always_ff @(posedge CK_t) begin
    for (int i = 0; i < DEPTH; i++)
      if (q_mem[i].rcd != '0) q_mem[i].rcd <= q_mem[i].rcd - RCD_W'(1);
    if (push_ok)
      q_mem[wr_ptr] <= '{req:  act_rw,
                         bank: BANK_W_MAX'(act_bank),
                         rcd:  act_rdy ? RCD_W'(TRCD - 1) : '0};
  end

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      state      <= CAS_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      q_full     <= 1'b0;
      overflow   <= 1'b0;
      last_cls   <= CLS_NONE;
      since_last <= '0;
      cas_rdy    <= 1'b0;
      cas_req    <= '0;
      cas_bank   <= '0;
    end else begin
      cas_rdy <= issue;
      count   <= count_nxt;
      q_full  <= (count_nxt == FULL);
      if (push_ok)          wr_ptr   <= wr_ptr + AW'(1);
      if (push && !push_ok) overflow <= 1'b1;
      if (issue) begin
        rd_ptr     <= rd_ptr + AW'(1);
        cas_req    <= head.req;
        cas_bank   <= head.bank[BANK_W-1:0];
        last_cls   <= head_cls;
        since_last <= '0;
      end else if (since_last != SL_MAX) begin
        since_last <= since_last + CNT_W'(1);
      end
      case (state)
        CAS_IDLE: if (count_nxt != '0) state <= CAS_WAIT;
        CAS_WAIT, CAS_CMD: begin
          if (issue)                 state <= CAS_CMD;
          else if (count_nxt != '0)  state <= CAS_WAIT;
          else                       state <= CAS_IDLE;
        end
        default: state <= CAS_IDLE;
      endcase
    end
  end

  assign q_count  = count;
  assign cas_idle = (state == CAS_IDLE) && empty;

`ifdef CAS_SCHED_STATS_EN
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue && head_cls == CLS_READ)  rd_cnt    <= rd_cnt + 32'd1;
      if (issue && head_cls == CLS_WRITE) wr_cnt    <= wr_cnt + 32'd1;
      if (state == CAS_WAIT)              stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign rd_cnt    = '0;
  assign wr_cnt    = '0;
  assign stall_cnt = '0;
`endif

endmodule
